// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture pipeline (palm locator and finger stage).
package gesture_pkg;

  localparam int unsigned COORD_W            = 8;
  localparam int unsigned IMAGE_WIDTH_DEF    = 120;
  localparam int unsigned IMAGE_HEIGHT_DEF   = 160;
  localparam int unsigned MIN_ROW_PIXELS_DEF = 10;
  localparam int unsigned MIN_PALM_ROWS_DEF  = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/palm_locator_if.sv
// Pixel-stream input and palm-result output bundle for palm_locator.
interface palm_locator_if;
  import gesture_pkg::*;

  logic   object_image;
  logic   pixel_valid;
  logic   sof;
  coord_t palm_width;
  coord_t palm_height;
  coord_t start_of_palm_r;
  coord_t start_of_palm_c;
  coord_t end_of_palm_r;
  coord_t end_of_palm_c;
  logic   palm_valid;

  // Pixel source / result consumer side.
  modport master (
    output object_image, pixel_valid, sof,
    input  palm_width, palm_height, start_of_palm_r, start_of_palm_c,
    input  end_of_palm_r, end_of_palm_c, palm_valid
  );

  // Palm locator side.
  modport slave (
    input  object_image, pixel_valid, sof,
    output palm_width, palm_height, start_of_palm_r, start_of_palm_c,
    output end_of_palm_r, end_of_palm_c, palm_valid
  );

endinterface

// File: rtl/row_run_stats.sv
// Per-row white-pixel statistics. The o_* values already include the pixel
// presented this cycle, so on the last column they describe the complete row.
module row_run_stats
  import gesture_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = IMAGE_WIDTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_accept,
  input  logic   i_pixel,
  input  coord_t i_col,
  output logic   o_row_done,
  output coord_t o_row_white,
  output coord_t o_first_c,
  output coord_t o_last_c
);

  localparam coord_t LastCol = coord_t'(IMAGE_WIDTH - 1);

  coord_t r_white;
  coord_t r_first;
  coord_t r_last;
  logic   r_any;

  logic   w_row_start;
  coord_t w_white_base;
  logic   w_any_base;

  // Column 0 starts a fresh row: ignore whatever the previous row left behind.
  always_comb begin
    w_row_start  = (i_col == '0);
    w_white_base = w_row_start ? '0 : r_white;
    w_any_base   = w_row_start ? 1'b0 : r_any;
    o_row_white  = i_pixel ? sat_inc(w_white_base) : w_white_base;
    o_first_c    = (i_pixel && !w_any_base) ? i_col : r_first;
    o_last_c     = i_pixel ? i_col : r_last;
    o_row_done   = i_accept && (i_col == LastCol);
  end

  // Statistics advance only on accepted pixels; stalls freeze them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_white <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_any   <= 1'b0;
    end else if (i_accept) begin
      r_white <= o_row_white;
      r_first <= o_first_c;
      r_last  <= o_last_c;
      r_any   <= w_any_base | i_pixel;
    end
  end

endmodule

// File: rtl/palm_locator.sv
// Finds the bounding box of the rows holding enough white pixels in each
// raster frame and publishes it (or all zeros) one cycle after frame end.
module palm_locator
  import gesture_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH    = IMAGE_WIDTH_DEF,
  parameter int unsigned IMAGE_HEIGHT   = IMAGE_HEIGHT_DEF,
  parameter int unsigned MIN_ROW_PIXELS = MIN_ROW_PIXELS_DEF,
  parameter int unsigned MIN_PALM_ROWS  = MIN_PALM_ROWS_DEF
) (
  input logic           clk,
  input logic           rst,
  palm_locator_if.slave bus
);

  localparam coord_t LastCol = coord_t'(IMAGE_WIDTH - 1);
  localparam coord_t LastRow = coord_t'(IMAGE_HEIGHT - 1);
  localparam coord_t MinPix  = coord_t'(MIN_ROW_PIXELS);
  localparam coord_t MinRows = coord_t'(MIN_PALM_ROWS);

  state_e r_state, w_state_next;
  coord_t r_col, r_row, w_col_next, w_row_next;
  coord_t r_top, r_bottom, r_left, r_right, r_palm_rows;
  coord_t w_top, w_bottom, w_left, w_right, w_palm_rows;
  coord_t r_palm_width, r_palm_height, r_start_r, r_start_c, r_end_r, r_end_c;
  logic   r_palm_valid;

  logic   w_start, w_accept, w_last_pix, w_clear, w_qual, w_row_done;
  coord_t w_col, w_row, w_row_white, w_first_c, w_last_c;

  // A valid sof restarts the frame from any state; otherwise only SCAN accepts.
  always_comb begin
    w_start    = bus.pixel_valid && bus.sof;
    w_accept   = w_start || (bus.pixel_valid && (r_state == SCAN));
    w_col      = w_start ? '0 : r_col;
    w_row      = w_start ? '0 : r_row;
    w_last_pix = w_accept && (w_row == LastRow) && (w_col == LastCol);
  end

  row_run_stats #(
    .IMAGE_WIDTH (IMAGE_WIDTH)
  ) u_row_stats (
    .clk         (clk),
    .rst         (rst),
    .i_accept    (w_accept),
    .i_pixel     (bus.object_image),
    .i_col       (w_col),
    .o_row_done  (w_row_done),
    .o_row_white (w_row_white),
    .o_first_c   (w_first_c),
    .o_last_c    (w_last_c)
  );

  // Next state and raster position of the following pixel.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    if (r_state == COMMIT) begin
      w_state_next = IDLE;
      w_col_next   = '0;
      w_row_next   = '0;
    end
    if (w_accept) begin
      w_state_next = w_last_pix ? COMMIT : SCAN;
      if (w_last_pix) begin
        w_col_next = '0;
        w_row_next = '0;
      end else if (w_col == LastCol) begin
        w_col_next = '0;
        w_row_next = w_row + 1'b1;
      end else begin
        w_col_next = w_col + 1'b1;
        w_row_next = w_row;
      end
    end
  end

  // Frame accumulators: cleared at commit or frame (re)start, then folded
  // with the just-completed row if it qualifies.
  always_comb begin
    w_clear     = w_start || (r_state == COMMIT);
    w_top       = w_clear ? '0 : r_top;
    w_bottom    = w_clear ? '0 : r_bottom;
    w_left      = w_clear ? '0 : r_left;
    w_right     = w_clear ? '0 : r_right;
    w_palm_rows = w_clear ? '0 : r_palm_rows;
    w_qual      = w_row_done && (w_row_white >= MinPix);
    if (w_qual) begin
      if (w_palm_rows == '0) begin
        w_top   = w_row;
        w_left  = w_first_c;
        w_right = w_last_c;
      end else begin
        if (w_first_c < w_left) w_left = w_first_c;
        if (w_last_c > w_right) w_right = w_last_c;
      end
      w_bottom    = w_row;
      w_palm_rows = sat_inc(w_palm_rows);
    end
  end

  // FSM, counters and accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_top       <= '0;
      r_bottom    <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_palm_rows <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_top       <= w_top;
      r_bottom    <= w_bottom;
      r_left      <= w_left;
      r_right     <= w_right;
      r_palm_rows <= w_palm_rows;
    end
  end

  // Result registers: all six update together in COMMIT and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_palm_width  <= '0;
      r_palm_height <= '0;
      r_start_r     <= '0;
      r_start_c     <= '0;
      r_end_r       <= '0;
      r_end_c       <= '0;
      r_palm_valid  <= 1'b0;
    end else begin
      r_palm_valid <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        if (r_palm_rows >= MinRows) begin
          r_palm_width  <= r_right - r_left + 1'b1;
          r_palm_height <= r_bottom - r_top + 1'b1;
          r_start_r     <= r_top;
          r_start_c     <= r_left;
          r_end_r       <= r_bottom;
          r_end_c       <= r_right;
        end else begin
          r_palm_width  <= '0;
          r_palm_height <= '0;
          r_start_r     <= '0;
          r_start_c     <= '0;
          r_end_r       <= '0;
          r_end_c       <= '0;
        end
      end
    end
  end

  assign bus.palm_width      = r_palm_width;
  assign bus.palm_height     = r_palm_height;
  assign bus.start_of_palm_r = r_start_r;
  assign bus.start_of_palm_c = r_start_c;
  assign bus.end_of_palm_r   = r_end_r;
  assign bus.end_of_palm_c   = r_end_c;
  assign bus.palm_valid      = r_palm_valid;

endmodule

// File: tb/tb_palm_locator.sv
// Directed bench for palm_locator on a reduced 80x82 frame.
module tb_palm_locator;
  import gesture_pkg::*;

  localparam int W = 80;
  localparam int H = 82;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  palm_locator_if bus ();

  palm_locator #(
    .IMAGE_WIDTH    (W),
    .IMAGE_HEIGHT   (H),
    .MIN_ROW_PIXELS (10),
    .MIN_PALM_ROWS  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int n_pulses = 0;
  int p0;

  // Counts palm_valid pulses (value held during the cycle just ended).
  always @(posedge clk) if (bus.palm_valid === 1'b1) n_pulses++;

  // 0 solid, 1 empty, 2 threshold, 3 short block, 4 rows 0..19 white
  function automatic logic white(input int kind, input int r, input int c);
    case (kind)
      0: return (r >= 40 && r <= 79 && c >= 30 && c <= 69);
      2: return (r == 10 && c <= 8) || (r >= 50 && r <= 59 && c >= 60 && c <= 79);
      3: return (r == 10 && c <= 8) || (r >= 50 && r <= 54 && c >= 60 && c <= 79);
      4: return (r <= 19);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int w, input int h, input int sr,
                           input int sc, input int er, input int ec);
    check({tag, ".width"},  32'(bus.palm_width),      32'(w));
    check({tag, ".height"}, 32'(bus.palm_height),     32'(h));
    check({tag, ".start_r"}, 32'(bus.start_of_palm_r), 32'(sr));
    check({tag, ".start_c"}, 32'(bus.start_of_palm_c), 32'(sc));
    check({tag, ".end_r"},  32'(bus.end_of_palm_r),   32'(er));
    check({tag, ".end_c"},  32'(bus.end_of_palm_c),   32'(ec));
  endtask

  // Stall cycle: pixel_valid low with junk on sof/object_image.
  task automatic drive_idle();
    @(posedge clk); #1;
    bus.pixel_valid  = 1'b0;
    bus.sof          = 1'($urandom_range(0, 1));
    bus.object_image = 1'($urandom_range(0, 1));
  endtask

  task automatic send_pixels(input int kind, input int stall_pct, input int count);
    for (int idx = 0; idx < count; idx++) begin
      while (int'($urandom_range(0, 99)) < stall_pct) drive_idle();
      @(posedge clk); #1;
      bus.pixel_valid  = 1'b1;
      bus.sof          = (idx == 0);
      bus.object_image = white(kind, idx / W, idx % W);
    end
  endtask

  // Last pixel accepted at the next edge (cycle N); pulse expected in N+2 only.
  task automatic finish_frame(input string tag, input int w, input int h, input int sr,
                              input int sc, input int er, input int ec);
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    @(negedge clk);
    check({tag, ".pv_n1"}, 32'(bus.palm_valid), 32'd0);
    @(negedge clk);
    check({tag, ".pv_n2"}, 32'(bus.palm_valid), 32'd1);
    check_out(tag, w, h, sr, sc, er, ec);
    @(negedge clk);
    check({tag, ".pv_n3"}, 32'(bus.palm_valid), 32'd0);
  endtask

  initial begin
    bus.pixel_valid  = 1'b0;
    bus.sof          = 1'b0;
    bus.object_image = 1'b0;

    #12;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.pv", 32'(bus.palm_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Valid pixels without sof in IDLE must be ignored.
    repeat (5) begin
      @(posedge clk); #1;
      bus.pixel_valid  = 1'b1;
      bus.sof          = 1'b0;
      bus.object_image = 1'b1;
    end

    send_pixels(0, 0, W * H);
    finish_frame("solid", 40, 40, 40, 30, 79, 69);
    check("solid.pulses", 32'(n_pulses), 32'd1);

    send_pixels(1, 0, W * H);
    finish_frame("empty", 0, 0, 0, 0, 0, 0);

    send_pixels(2, 0, W * H);
    finish_frame("thresh", 20, 10, 50, 60, 59, 79);

    send_pixels(3, 0, W * H);
    finish_frame("short", 0, 0, 0, 0, 0, 0);

    send_pixels(0, 30, W * H);
    finish_frame("stall", 40, 40, 40, 30, 79, 69);
    check("stall.pulses", 32'(n_pulses), 32'd5);

    // Restart: sof arrives where (20,5) would have been.
    p0 = n_pulses;
    send_pixels(4, 0, 20 * W + 5);
    @(negedge clk);
    check_out("restart.hold", 40, 40, 40, 30, 79, 69);
    check("restart.no_pulse", 32'(n_pulses), 32'(p0));
    send_pixels(2, 0, W * H);
    finish_frame("restart", 20, 10, 50, 60, 59, 79);
    check("restart.pulses", 32'(n_pulses), 32'(p0 + 1));

    // Asynchronous reset between edges, mid-frame.
    send_pixels(4, 0, 30 * W);
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_out("areset", 0, 0, 0, 0, 0, 0);
    check("areset.pv", 32'(bus.palm_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_pixels(0, 0, W * H);
    finish_frame("after_reset", 40, 40, 40, 30, 79, 69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/palm_locator.md
# palm_locator

Upstream stage of finger identification. Scans the binarised `object_image` pixel stream one raster frame at a time and finds the bounding box of the palm, built only from rows that contain enough white pixels. At each frame end it publishes `palm_width`, `palm_height`, `start_of_palm_r/c` and `end_of_palm_r/c`. `palm_width == 0` means "no palm", which the downstream finger stage uses as its enable.

## Interface
- `IMAGE_WIDTH`, 120: columns per row.
- `IMAGE_HEIGHT`, 160: rows per frame.
- `MIN_ROW_PIXELS`, 10: minimum white pixels for a row to count as a palm row.
- `MIN_PALM_ROWS`, 8: minimum palm rows for a frame to report a palm.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `object_image`  in  1  binarised pixel, 1 = white.
- `pixel_valid`  in  1  pixel present this cycle.
- `sof`  in  1  first pixel of a frame; meaningful only with `pixel_valid`.
- `palm_width`, `palm_height`  out  8  box size; 0 when no palm.
- `start_of_palm_r`, `start_of_palm_c`  out  8  top row and leftmost column of the box.
- `end_of_palm_r`, `end_of_palm_c`  out  8  bottom row and rightmost column of the box.
- `palm_valid`  out  1  one-cycle pulse when results update.

## Operation
- **FSM**
  - IDLE: wait for `sof & pixel_valid`, then go to SCAN with that pixel taken as (0,0).
  - SCAN: accept pixels.
  - COMMIT: one cycle; update outputs, then return to IDLE.
- **Counters**
  - `col`, `row` are 8-bit, unsigned, and advance only on accepted pixels.
  - `col` wraps from IMAGE_WIDTH-1 to 0 and increments `row`.
  - The pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) is the last of the frame; go to COMMIT.
- **Per-row statistics**, cleared at column 0:
  - `row_white` (8-bit, saturating at 255).
  - `first_c` = column of the first white pixel.
  - `last_c` = column of the last white pixel.
  - On the last column, the evaluation includes the current pixel combinationally.
- **Palm-row test:** a row qualifies if `row_white >= MIN_ROW_PIXELS`. For each qualifying row:
  - `top` is set on the first qualifying row only.
  - `bottom` = this row.
  - `left` = min(`left`, `first_c`).
  - `right` = max(`right`, `last_c`).
  - `palm_rows` += 1, saturating.
- **COMMIT with `palm_rows >= MIN_PALM_ROWS`:**
  - `palm_width` = `right` - `left` + 1.
  - `palm_height` = `bottom` - `top` + 1.
  - The start/end outputs take `top`/`left` and `bottom`/`right`.
  - The subtractions are in-range by construction, since `right >= left` and `bottom >= top`.
- **COMMIT without a palm:** all six outputs go to 0.
- **Every COMMIT:** `palm_valid` = 1 and the accumulators clear.
- **Output hold:** outputs hold between commits and are never partially updated.

## Timing
- **Reset:** every output is 0 and the FSM is in IDLE, immediately on `rst` low (asynchronous). Frame accumulation is discarded.
- **Latency:** the last pixel is accepted in cycle N. COMMIT is cycle N+1, and outputs plus the `palm_valid` pulse are visible from cycle N+2 (registered).
- **Stalls:** `pixel_valid` low freezes counters and statistics. Results must not depend on the stall pattern.
- **`sof & pixel_valid` in SCAN:** discard the partial frame and restart with this pixel as (0,0). Outputs are untouched and there is no `palm_valid`.
- **`sof & pixel_valid` in COMMIT:** the commit completes normally and the pixel is accepted as (0,0) of the next frame, going directly to SCAN.
- **`pixel_valid` without `sof` in IDLE:** ignored.
- **`sof` without `pixel_valid`:** ignored in all states.

## Structure
- **Shared package `gesture_pkg`:**
  - `COORD_W` = 8.
  - Default `IMAGE_WIDTH`/`IMAGE_HEIGHT` (also used by the finger stage).
  - Threshold defaults.
  - FSM state enum {IDLE, SCAN, COMMIT}.
- **Sub-module `row_run_stats`:**
  - Per-row white count, `first_c`, `last_c`, and a `row_done` strobe with combinational last-pixel inclusion.
  - Parent holds the FSM, the frame accumulators and the output registers.

## Test plan
- **Solid palm:** white rectangle at rows 40..79, cols 30..69; frame otherwise black. Expect `palm_width`=40, `palm_height`=40, start=(40,30), end=(79,69), one `palm_valid` pulse 2 cycles after the last pixel.
- **Empty frame:** all black after a palm frame. Expect all six outputs 0 and `palm_valid` pulsed.
- **Threshold filter:** row 10 has 9 white pixels at cols 0..8; block at rows 50..59, cols 60..79 (20 per row). Expect start=(50,60), end=(59,79), width 20, height 10. Rows 50..54 only → 5 palm rows < 8 → all zeros.
- **Stall invariance:** same stimulus as Solid palm with `pixel_valid` randomly deasserted about 30% of cycles. Expect results identical to Solid palm.
- **Restart:** `sof` reasserted at (20,5) mid-frame. No `palm_valid` pulse, prior outputs unchanged, and the next full frame is reported correctly.
- **Async reset:** `rst` low mid-frame between clock edges. Expect outputs 0 before the next edge; the next frame after release is measured correctly.
